// File: rtl/microwave_pkg.sv
// Shared types and helpers for the microwave sequencer: FSM states, BCD digit type and keypad decode.
package microwave_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      ENTRY = 3'd1,
      COOK  = 3'd2,
      PAUSE = 3'd3,
      DONE  = 3'd4
   } state_t;

   typedef logic [3:0] bcd_t;

   localparam bcd_t MAX_BCD  = 4'd9;
   localparam bcd_t MAX_TENS = 4'd5;

   function automatic logic key_onehot(input logic [9:0] k);
      return (k != 10'd0) && ((k & (k - 10'd1)) == 10'd0);
   endfunction

   function automatic bcd_t key_digit(input logic [9:0] k);
      bcd_t d;
      d = 4'd0;
      for (int i = 0; i < 10; i++) begin
         if (k[i]) d = bcd_t'(i);
      end
      return d;
   endfunction

endpackage

// File: rtl/bcd_down_counter.sv
// min:sec BCD display register: clear, shift-in of a keypad digit, and one-second decrement
// with borrow (seconds wrap to 59, minute digits borrow in BCD).
module bcd_down_counter
   import microwave_pkg::*;
#(
   parameter int MIN_DIGITS = 1
)
(
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    clr,
   input  logic                    shift,
   input  logic                    dec,
   input  logic [3:0]              digit,
   output logic [4*MIN_DIGITS-1:0] minutes,
   output logic [3:0]              tens,
   output logic [3:0]              ones,
   output logic                    zero,
   output logic                    at_one
);

   localparam int NDIG = MIN_DIGITS + 2;
   localparam int W    = 4 * NDIG;

   // Digit 0 is seconds, digit 1 tens of seconds, the rest are minute digits.
   logic [W-1:0] value;
   logic [W-1:0] dec_value;
   logic         borrow;

   always_comb begin
      dec_value = value;
      borrow    = 1'b1;
      for (int i = 0; i < NDIG; i++) begin
         if (borrow) begin
            if (value[4*i +: 4] == 4'd0) begin
               dec_value[4*i +: 4] = (i == 1) ? MAX_TENS : MAX_BCD;
            end else begin
               dec_value[4*i +: 4] = value[4*i +: 4] - 4'd1;
               borrow              = 1'b0;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         value <= '0;
      end else if (clr) begin
         value <= '0;
      end else if (shift) begin
         value <= {value[W-5:0], digit};
      end else if (dec) begin
         value <= dec_value;
      end
   end

   assign ones    = value[3:0];
   assign tens    = value[7:4];
   assign minutes = value[W-1:8];
   assign zero    = (value == '0);
   assign at_one  = (value == W'(1));

endmodule

// File: rtl/microwave_sequencer.sv
// Microwave control FSM: keypad entry, countdown, pause/resume, power duty window and done state.
// Optional MICROWAVE_DONE_BEEP_EN adds a beep output held for three ticks after cooking ends.
module microwave_sequencer
   import microwave_pkg::*;
#(
   parameter int TICK_DIV     = 50_000_000,
   parameter int MIN_DIGITS   = 1,
   parameter int POWER_LEVELS = 10
)
(
   input  logic                    clk,
   input  logic                    rst,
   input  logic [9:0]              keypad,
   input  logic                    start,
   input  logic                    stop,
   input  logic                    clear,
   input  logic                    door_closed,
   input  logic [3:0]              power_lvl,
   output logic [4*MIN_DIGITS-1:0] minutes,
   output logic [3:0]              tens,
   output logic [3:0]              ones,
   output logic                    mag_on,
   output logic [2:0]              state,
   output logic                    done
`ifdef MICROWAVE_DONE_BEEP_EN
   ,
   output logic                    beep
`endif
);

   localparam int              TICK_W    = $clog2(TICK_DIV);
   localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
   localparam logic [3:0]      PL        = 4'(POWER_LEVELS);

   function automatic logic [3:0] sat_power(input logic [3:0] req);
      return (req == 4'd0 || req > PL) ? PL : req;
   endfunction

   state_t              st;
   state_t              nxt;
   logic [9:0]          key_prev;
   logic [9:0]          key_rise;
   logic                key_new;
   logic [TICK_W-1:0]   tick_cnt;
   logic [TICK_W-1:0]   tick_nxt;
   logic                tick;
   logic [3:0]          power;
   logic [3:0]          power_nxt;
   logic [3:0]          window;
   logic [3:0]          window_nxt;
   logic                start_ok;
   logic                t_clr;
   logic                t_shift;
   logic                t_dec;
   logic                time_zero;
   logic                time_one;
`ifdef MICROWAVE_DONE_BEEP_EN
   logic [1:0]          beep_ticks;
`endif

   bcd_down_counter #(.MIN_DIGITS(MIN_DIGITS)) u_time (
      .clk     (clk),
      .rst     (rst),
      .clr     (t_clr),
      .shift   (t_shift),
      .dec     (t_dec),
      .digit   (key_digit(keypad)),
      .minutes (minutes),
      .tens    (tens),
      .ones    (ones),
      .zero    (time_zero),
      .at_one  (time_one)
   );

   assign key_rise = keypad & ~key_prev;
   assign key_new  = key_onehot(keypad) && (key_rise != 10'd0);
   assign tick     = (tick_cnt == TICK_LAST);
   assign start_ok = door_closed && !time_zero;

   // Priority: clear > door open > stop > start > keypad.
   always_comb begin
      nxt        = st;
      t_clr      = 1'b0;
      t_shift    = 1'b0;
      t_dec      = 1'b0;
      tick_nxt   = tick_cnt;
      power_nxt  = power;
      window_nxt = window;
      if (clear) begin
         nxt        = IDLE;
         t_clr      = 1'b1;
         power_nxt  = PL;
         window_nxt = 4'd0;
         tick_nxt   = '0;
      end else begin
         case (st)
            IDLE, ENTRY: begin
               if (st == ENTRY && start && start_ok) begin
                  nxt        = COOK;
                  power_nxt  = sat_power(power_lvl);
                  window_nxt = 4'd0;
                  tick_nxt   = '0;
               end else if (key_new) begin
                  t_shift = 1'b1;
                  nxt     = ENTRY;
               end
            end
            COOK: begin
               if (!door_closed || stop) begin
                  nxt = PAUSE;
               end else if (tick) begin
                  tick_nxt   = '0;
                  t_dec      = 1'b1;
                  window_nxt = (window == PL - 4'd1) ? 4'd0 : window + 4'd1;
                  if (time_one) nxt = DONE;
               end else begin
                  tick_nxt = tick_cnt + TICK_W'(1);
               end
            end
            PAUSE: begin
               if (stop) begin
                  nxt   = IDLE;
                  t_clr = 1'b1;
               end else if (start && start_ok) begin
                  nxt = COOK;
               end
            end
            DONE: begin
               if (key_rise != 10'd0 || start || stop) begin
                  nxt = IDLE;
               end else if (tick) begin
                  tick_nxt = '0;
               end else begin
                  tick_nxt = tick_cnt + TICK_W'(1);
               end
            end
            default: nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         st       <= IDLE;
         key_prev <= '0;
         tick_cnt <= '0;
         power    <= PL;
         window   <= 4'd0;
         mag_on   <= 1'b0;
         done     <= 1'b0;
`ifdef MICROWAVE_DONE_BEEP_EN
         beep       <= 1'b0;
         beep_ticks <= 2'd0;
`endif
      end else begin
         st       <= nxt;
         key_prev <= keypad;
         tick_cnt <= tick_nxt;
         power    <= power_nxt;
         window   <= window_nxt;
         mag_on   <= (nxt == COOK) && (window_nxt < power_nxt);
         done     <= (nxt == DONE);
`ifdef MICROWAVE_DONE_BEEP_EN
         if (nxt == DONE && st != DONE) begin
            beep       <= 1'b1;
            beep_ticks <= 2'd0;
         end else if (nxt != DONE) begin
            beep <= 1'b0;
         end else if (tick && beep) begin
            if (beep_ticks == 2'd2) beep <= 1'b0;
            else                    beep_ticks <= beep_ticks + 2'd1;
         end
`endif
      end
   end

   assign state = st;

endmodule

// File: tb/tb_microwave_sequencer.sv
// Directed bench for microwave_sequencer with a per-cycle behavioural model and literal checkpoints.
module tb_microwave_sequencer;

   localparam int TD = 4;
   localparam int MD = 2;
   localparam int PL = 10;

   logic            clk = 1'b0;
   logic            rst = 1'b0;
   logic [9:0]      keypad = '0;
   logic            start = 1'b0;
   logic            stop = 1'b0;
   logic            clear = 1'b0;
   logic            door_closed = 1'b1;
   logic [3:0]      power_lvl = 4'd0;
   logic [4*MD-1:0] minutes;
   logic [3:0]      tens;
   logic [3:0]      ones;
   logic            mag_on;
   logic [2:0]      state;
   logic            done;
`ifdef MICROWAVE_DONE_BEEP_EN
   logic            beep;
`endif
   logic [15:0]     disp;

   int n_cmp = 0;
   int n_bad = 0;
   bit chk_en = 1'b0;

   assign disp = {minutes, tens, ones};

   always #5 clk = ~clk;

   microwave_sequencer #(.TICK_DIV(TD), .MIN_DIGITS(MD), .POWER_LEVELS(PL)) dut (
      .clk         (clk),
      .rst         (rst),
      .keypad      (keypad),
      .start       (start),
      .stop        (stop),
      .clear       (clear),
      .door_closed (door_closed),
      .power_lvl   (power_lvl),
      .minutes     (minutes),
      .tens        (tens),
      .ones        (ones),
      .mag_on      (mag_on),
      .state       (state),
      .done        (done)
`ifdef MICROWAVE_DONE_BEEP_EN
      ,
      .beep        (beep)
`endif
   );

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: states 0 idle, 1 entry, 2 cook, 3 pause, 4 done; digits as decimal numbers.
   int         m_st;
   int         m_pow;
   int         m_win;
   int         m_sub;
   int         m_beep_left;
   int         m_dig [4];
   logic [9:0] m_kprev;

   function automatic bit m_is_zero();
      return (m_dig[0] == 0) && (m_dig[1] == 0) && (m_dig[2] == 0) && (m_dig[3] == 0);
   endfunction

   task automatic m_set_zero();
      for (int i = 0; i < 4; i++) m_dig[i] = 0;
   endtask

   task automatic m_reset();
      m_st = 0; m_pow = PL; m_win = 0; m_sub = 0; m_beep_left = 0; m_kprev = '0;
      m_set_zero();
   endtask

   task automatic m_countdown();
      int mins;
      if (m_dig[0] > 0) begin
         m_dig[0] = m_dig[0] - 1;
      end else if (m_dig[1] > 0) begin
         m_dig[1] = m_dig[1] - 1;
         m_dig[0] = 9;
      end else begin
         mins = m_dig[3] * 10 + m_dig[2] - 1;
         m_dig[3] = mins / 10;
         m_dig[2] = mins % 10;
         m_dig[1] = 5;
         m_dig[0] = 9;
      end
   endtask

   task automatic m_step();
      bit any_rise;
      bit new_key;
      int d;
      any_rise = (keypad & ~m_kprev) != 10'd0;
      new_key  = ($countones(keypad) == 1) && any_rise;
      d = 0;
      for (int i = 0; i < 10; i++) if (keypad[i]) d = i;
      if (clear) begin
         m_st = 0; m_set_zero(); m_pow = PL; m_win = 0; m_sub = 0;
      end else if (m_st == 0 || m_st == 1) begin
         if (m_st == 1 && start && door_closed && !m_is_zero()) begin
            m_st = 2;
            m_pow = (power_lvl == 0 || power_lvl > PL) ? PL : int'(power_lvl);
            m_win = 0; m_sub = 0;
         end else if (new_key) begin
            m_dig[3] = m_dig[2]; m_dig[2] = m_dig[1]; m_dig[1] = m_dig[0]; m_dig[0] = d;
            m_st = 1;
         end
      end else if (m_st == 2) begin
         if (!door_closed || stop) begin
            m_st = 3;
         end else if (m_sub == TD - 1) begin
            m_sub = 0;
            m_countdown();
            m_win = (m_win + 1) % PL;
            if (m_is_zero()) begin
               m_st = 4; m_beep_left = 3;
            end
         end else begin
            m_sub++;
         end
      end else if (m_st == 3) begin
         if (stop) begin
            m_st = 0; m_set_zero();
         end else if (start && door_closed) begin
            m_st = 2;
         end
      end else begin
         if (any_rise || start || stop) begin
            m_st = 0;
         end else if (m_sub == TD - 1) begin
            m_sub = 0;
            if (m_beep_left > 0) m_beep_left--;
         end else begin
            m_sub++;
         end
      end
      m_kprev = keypad;
   endtask

   always @(posedge clk or posedge rst) begin
      if (rst) m_reset();
      else     m_step();
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("model_state", int'(state), m_st);
         check("model_minutes", int'(minutes), m_dig[3] * 16 + m_dig[2]);
         check("model_tens", int'(tens), m_dig[1]);
         check("model_ones", int'(ones), m_dig[0]);
         check("model_mag_on", int'(mag_on), int'(m_st == 2 && m_win < m_pow));
         check("model_done", int'(done), int'(m_st == 4));
`ifdef MICROWAVE_DONE_BEEP_EN
         check("model_beep", int'(beep), int'(m_st == 4 && m_beep_left > 0));
`endif
      end
   end

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic press(input int d);
      keypad = 10'(1 << d);
      step(1);
      keypad = '0;
      step(1);
   endtask

   task automatic do_start();
      start = 1'b1; step(1); start = 1'b0;
   endtask

   task automatic do_stop();
      stop = 1'b1; step(1); stop = 1'b0;
   endtask

   task automatic do_clear();
      clear = 1'b1; step(1); clear = 1'b0;
   endtask

   initial begin
      #1 rst = 1'b1;
      step(2);
      chk_en = 1'b1;
      check("rst_state", int'(state), 0);
      check("rst_disp", int'(disp), 'h0000);
      check("rst_mag_on", int'(mag_on), 0);
      check("rst_done", int'(done), 0);
      rst = 1'b0;
      step(1);

      // Entry and countdown with borrow.
      press(1); press(3); press(0);
      check("entry_130", int'(disp), 'h0130);
      check("entry_state", int'(state), 1);
      do_start();
      check("cook_state", int'(state), 2);
      check("cook_mag_on", int'(mag_on), 1);
      step(3);
      check("cook_hold_130", int'(disp), 'h0130);
      step(1);
      check("cook_129", int'(disp), 'h0129);
      step(116);
      check("cook_100", int'(disp), 'h0100);
      step(4);
      check("cook_059", int'(disp), 'h0059);
      #2 rst = 1'b1;
      #1;
      check("async_rst_mag", int'(mag_on), 0);
      check("async_rst_state", int'(state), 0);
      step(1);
      rst = 1'b0;
      step(1);

      // Pause / resume to done; power request above range saturates.
      power_lvl = 4'd12;
      press(0); press(5);
      do_start();
      step(8);
      check("pause_at_003", int'(disp), 'h0003);
      check("sat_power_mag", int'(mag_on), 1);
      do_stop();
      check("pause_state", int'(state), 3);
      check("pause_mag_off", int'(mag_on), 0);
      step(20);
      check("pause_hold", int'(disp), 'h0003);
      do_start();
      check("resume_state", int'(state), 2);
      step(12);
      check("done_state", int'(state), 4);
      check("done_flag", int'(done), 1);
      check("done_mag_off", int'(mag_on), 0);
      check("done_disp", int'(disp), 'h0000);
`ifdef MICROWAVE_DONE_BEEP_EN
      check("beep_on", int'(beep), 1);
      step(11);
      check("beep_still_on", int'(beep), 1);
      step(1);
      check("beep_off", int'(beep), 0);
`else
      step(12);
`endif
      check("done_stays", int'(state), 4);
      do_stop();
      check("done_exit", int'(state), 0);
      check("done_exit_flag", int'(done), 0);

      // Door opened mid-cook.
      power_lvl = 4'd0;
      press(0); press(9);
      do_start();
      step(8);
      check("door_007", int'(disp), 'h0007);
      door_closed = 1'b0;
      step(1);
      check("door_pause", int'(state), 3);
      check("door_mag_off", int'(mag_on), 0);
      do_start();
      check("door_start_ignored", int'(state), 3);
      door_closed = 1'b1;
      step(1);
      do_start();
      check("door_resume", int'(state), 2);
      do_clear();
      check("clear_idle", int'(state), 0);

      // Duty cycle: 3 of 10 ticks on.
      power_lvl = 4'd3;
      press(2); press(0);
      do_start();
      check("duty_on0", int'(mag_on), 1);
      step(11);
      check("duty_on_end", int'(mag_on), 1);
      step(1);
      check("duty_off", int'(mag_on), 0);
      step(27);
      check("duty_off_end", int'(mag_on), 0);
      step(1);
      check("duty_on_again", int'(mag_on), 1);
      check("duty_disp", int'(disp), 'h0010);
      do_clear();

      // Clear beats start; zero time cannot start.
      press(4);
      check("pre_clear", int'(disp), 'h0004);
      start = 1'b1; clear = 1'b1;
      step(1);
      start = 1'b0; clear = 1'b0;
      check("clear_start_state", int'(state), 0);
      check("clear_start_disp", int'(disp), 'h0000);
      do_start();
      check("idle_start_ignored", int'(state), 0);
      press(0);
      do_start();
      check("zero_start_ignored", int'(state), 1);

      // Two minute digits, held key, multi-key, minute borrow.
      do_clear();
      press(1); press(2); press(3); press(4); press(5);
      check("msd_dropped", int'(disp), 'h2345);
      keypad = 10'(1 << 7);
      step(3);
      keypad = '0;
      step(1);
      check("held_key_once", int'(disp), 'h3457);
      keypad = 10'b0000000011;
      step(1);
      keypad = '0;
      step(1);
      check("multi_key_ignored", int'(disp), 'h3457);
      do_clear();
      press(1); press(0); press(0); press(0);
      do_start();
      step(4);
      check("minute_borrow", int'(disp), 'h0959);
      do_clear();
      step(2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
